// File: rtl/counter_decoder.sv
// counter_decoder: saturating 0..7 queue counter with wait-time ROM and
// three seven-segment displays (queue count, wait-time units, wait-time tens).
// Optional feature macro: CLKUP_EN (count and alarm update only when clkup=1).

module counter_decoder (
   input  logic       clk,
   input  logic       reset,
   input  logic       clkup,
   input  logic       switch,
   input  logic [1:0] tcount,
   output logic [6:0] pcount,
   output logic [6:0] wtime1,
   output logic [6:0] wtime2,
   output logic       full_flag,
   output logic       empty_flag,
   output logic       alarm
);

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned BCD_W   = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(7);

   logic [CNT_W-1:0] count_q, count_d;
   logic             alarm_q, alarm_d;
   logic             step_en;
   logic [1:0]       tellers;
   logic [BCD_W-1:0] wait_bcd;

`ifdef CLKUP_EN
   assign step_en = clkup;
`else
   assign step_en = 1'b1;
   logic unused_clkup;
   assign unused_clkup = clkup;
`endif

   // Wait time in BCD, indexed by active tellers (1..3) and queue count (0..7).
   function automatic logic [BCD_W-1:0] wait_rom(input logic [1:0] tel,
                                                  input logic [CNT_W-1:0] cnt);
      logic [BCD_W-1:0] w;
      w = 8'h00;
      case (tel)
         2'd2: begin
            case (cnt)
               4'd1: w = 8'h03;
               4'd2: w = 8'h04;
               4'd3: w = 8'h06;
               4'd4: w = 8'h07;
               4'd5: w = 8'h09;
               4'd6: w = 8'h10;
               4'd7: w = 8'h12;
               default: w = 8'h00;
            endcase
         end
         2'd3: begin
            case (cnt)
               4'd1: w = 8'h03;
               4'd2: w = 8'h04;
               4'd3: w = 8'h05;
               4'd4: w = 8'h06;
               4'd5: w = 8'h07;
               4'd6: w = 8'h08;
               4'd7: w = 8'h09;
               default: w = 8'h00;
            endcase
         end
         default: begin
            case (cnt)
               4'd1: w = 8'h03;
               4'd2: w = 8'h06;
               4'd3: w = 8'h09;
               4'd4: w = 8'h12;
               4'd5: w = 8'h15;
               4'd6: w = 8'h18;
               4'd7: w = 8'h21;
               default: w = 8'h00;
            endcase
         end
      endcase
      return w;
   endfunction

   // Next count and alarm: saturating step, alarm flags an out-of-range request.
   always_comb begin
      count_d = count_q;
      alarm_d = alarm_q;
      if (step_en) begin
         if (switch) begin
            if (count_q < CNT_MAX) begin
               count_d = count_q + CNT_W'(1);
               alarm_d = 1'b0;
            end else begin
               alarm_d = 1'b1;
            end
         end else begin
            if (count_q != '0) begin
               count_d = count_q - CNT_W'(1);
               alarm_d = 1'b0;
            end else begin
               alarm_d = 1'b1;
            end
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         alarm_q <= 1'b0;
      end else begin
         count_q <= count_d;
         alarm_q <= alarm_d;
      end
   end

   // A teller count of zero is treated as one teller.
   always_comb begin
      tellers  = (tcount == 2'd0) ? 2'd1 : tcount;
      wait_bcd = wait_rom(tellers, count_q);
   end

   assign full_flag  = (count_q == CNT_MAX);
   assign empty_flag = (count_q == '0);
   assign alarm      = alarm_q;

   seg7_decoder u_seg_count (.code(count_q),       .seg_c(pcount));
   seg7_decoder u_seg_units (.code(wait_bcd[3:0]), .seg_c(wtime1));
   seg7_decoder u_seg_tens  (.code(wait_bcd[7:4]), .seg_c(wtime2));

endmodule

// Hex to active-high seven-segment image, bit6=a .. bit0=g.
module seg7_decoder (
   input  logic [3:0] code,
   output logic [6:0] seg_c
);

   // Segment lookup.
   always_comb begin
      seg_c = 7'h00;
      case (code)
         4'h0: seg_c = 7'h7E;
         4'h1: seg_c = 7'h30;
         4'h2: seg_c = 7'h6D;
         4'h3: seg_c = 7'h79;
         4'h4: seg_c = 7'h33;
         4'h5: seg_c = 7'h5B;
         4'h6: seg_c = 7'h5F;
         4'h7: seg_c = 7'h70;
         4'h8: seg_c = 7'h7F;
         4'h9: seg_c = 7'h7B;
         4'hA: seg_c = 7'h77;
         4'hB: seg_c = 7'h1F;
         4'hC: seg_c = 7'h4E;
         4'hD: seg_c = 7'h3D;
         4'hE: seg_c = 7'h4F;
         4'hF: seg_c = 7'h47;
         default: seg_c = 7'h00;
      endcase
   end

endmodule

// File: tb/tb_counter_decoder.sv
// Scoreboard bench for counter_decoder: a behavioural model pushes expected
// outputs when stimulus is applied; they are popped and compared after the edge.

module tb_counter_decoder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clkup = 1'b0;
   logic       switch = 1'b0;
   logic [1:0] tcount = 2'd1;
   logic [6:0] pcount, wtime1, wtime2;
   logic       full_flag, empty_flag, alarm;

   typedef struct packed {
      logic [6:0] pc;
      logic [6:0] w1;
      logic [6:0] w2;
      logic       full;
      logic       empty;
      logic       alm;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   m_cnt = 0;
   logic m_alm = 1'b0;

   counter_decoder dut (
      .clk(clk), .reset(reset), .clkup(clkup), .switch(switch), .tcount(tcount),
      .pcount(pcount), .wtime1(wtime1), .wtime2(wtime2),
      .full_flag(full_flag), .empty_flag(empty_flag), .alarm(alarm)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg(input int v);
      logic [6:0] s;
      case (v)
         0: s = 7'h7E;  1: s = 7'h30;  2: s = 7'h6D;  3: s = 7'h79;
         4: s = 7'h33;  5: s = 7'h5B;  6: s = 7'h5F;  7: s = 7'h70;
         8: s = 7'h7F;  9: s = 7'h7B;  default: s = 7'h00;
      endcase
      return s;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rst, input logic sw, input logic [1:0] tc, input logic cu);
      exp_t e;
      int   t;
      int   w;
      logic en;
      reset  = rst;
      switch = sw;
      tcount = tc;
      clkup  = cu;
`ifdef CLKUP_EN
      en = cu;
`else
      en = 1'b1;
`endif
      if (rst) begin
         m_cnt = 0;
         m_alm = 1'b0;
      end else if (en) begin
         if (sw) begin
            if (m_cnt < 7) begin m_cnt++; m_alm = 1'b0; end
            else m_alm = 1'b1;
         end else begin
            if (m_cnt > 0) begin m_cnt--; m_alm = 1'b0; end
            else m_alm = 1'b1;
         end
      end
      t = (tc == 2'd0) ? 1 : int'(tc);
      w = (m_cnt == 0) ? 0 : (3 * (m_cnt + t - 1)) / t;
      e.pc    = seg(m_cnt);
      e.w1    = seg(w % 10);
      e.w2    = seg(w / 10);
      e.full  = (m_cnt == 7);
      e.empty = (m_cnt == 0);
      e.alm   = m_alm;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("pcount",     32'(pcount),     32'(e.pc));
      check("wtime1",     32'(wtime1),     32'(e.w1));
      check("wtime2",     32'(wtime2),     32'(e.w2));
      check("full_flag",  32'(full_flag),  32'(e.full));
      check("empty_flag", 32'(empty_flag), 32'(e.empty));
      check("alarm",      32'(alarm),      32'(e.alm));
   endtask

   initial begin
      // Reset state.
      step(1'b1, 1'b1, 2'd1, 1'b1);
      step(1'b1, 1'b1, 2'd1, 1'b1);
      check("rst_pcount", 32'(pcount), 32'h7E);
      check("rst_wtime1", 32'(wtime1), 32'h7E);
      check("rst_wtime2", 32'(wtime2), 32'h7E);
      check("rst_empty",  32'(empty_flag), 32'd1);
      check("rst_alarm",  32'(alarm), 32'd0);

      // Three arrivals with one teller: W=09.
      repeat (3) step(1'b0, 1'b1, 2'd1, 1'b1);
      check("c3_pcount", 32'(pcount), 32'h79);
      check("c3_wtime1", 32'(wtime1), 32'h7B);
      check("c3_wtime2", 32'(wtime2), 32'h7E);

      // Fill to 7 with two tellers: W=12, then one more up raises alarm.
      repeat (4) step(1'b0, 1'b1, 2'd2, 1'b1);
      check("c7_full",   32'(full_flag), 32'd1);
      check("c7_wtime2", 32'(wtime2), 32'h30);
      check("c7_wtime1", 32'(wtime1), 32'h6D);
      step(1'b0, 1'b1, 2'd2, 1'b1);
      check("c7_alarm",  32'(alarm), 32'd1);
      check("c7_hold",   32'(pcount), 32'h70);

      // Down to 5 with three tellers: W=07, alarm clears.
      repeat (2) step(1'b0, 1'b0, 2'd3, 1'b1);
      check("c5_wtime1", 32'(wtime1), 32'h70);
      check("c5_wtime2", 32'(wtime2), 32'h7E);
      check("c5_alarm",  32'(alarm), 32'd0);

      // Drain past zero, then one arrival.
      repeat (5) step(1'b0, 1'b0, 2'd3, 1'b1);
      step(1'b0, 1'b0, 2'd3, 1'b1);
      check("c0_empty", 32'(empty_flag), 32'd1);
      check("c0_alarm", 32'(alarm), 32'd1);
      step(1'b0, 1'b1, 2'd3, 1'b1);
      check("c1_pcount", 32'(pcount), 32'h30);
      check("c1_alarm",  32'(alarm), 32'd0);

      // Reset mid-count at 4.
      repeat (3) step(1'b0, 1'b1, 2'd1, 1'b1);
      check("c4_pcount", 32'(pcount), 32'h33);
      step(1'b1, 1'b1, 2'd1, 1'b1);
      check("mid_rst_pcount", 32'(pcount), 32'h7E);
      check("mid_rst_wtime1", 32'(wtime1), 32'h7E);
      check("mid_rst_wtime2", 32'(wtime2), 32'h7E);

      // Random traffic including tcount=0, clkup toggling and sparse resets.
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
